regfile_cmd_ctrl: RTL and testbench

Command-side master for the RegFile block: it drives RegFile's WrEn/RdEn/Address/WrData and consumes RdData. It parses a byte stream from the serial receiver into register write and read commands. Read results are returned MSB-byte-first over a valid/ready byte interface to the serial transmitter. It sits between the UART RX/TX path and RegFile in the system-control domain.

---
 rtl/regfile_cmd_ctrl_pkg.sv | 19 +
 rtl/regfile_cmd_ctrl_if.sv | 28 ++
 rtl/regfile_cmd_ctrl.sv | 109 ++++++++++
 tb/tb_regfile_cmd_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_cmd_ctrl_pkg.sv
// Shared definitions for the RegFile command controller: FSM states and
// default command bytes that open write and read frames.
package regfile_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_EXEC,
        RD_ADDR,
        RD_EXEC,
        RD_WAIT,
        TX_SEND
    } state_t;

    localparam logic [7:0] WR_CMD_DEFAULT = 8'hAA;
    localparam logic [7:0] RD_CMD_DEFAULT = 8'hBB;

endpackage

// File: rtl/regfile_cmd_ctrl_if.sv
// Byte-stream, response and RegFile signals of the command controller.
// master is the controller side, slave is the UART/RegFile side.
interface regfile_cmd_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 3
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             WrEn;
    logic             RdEn;
    logic [ADDR-1:0]  Address;
    logic [WIDTH-1:0] WrData;
    logic [WIDTH-1:0] RdData;
    logic             busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, RdData,
        output tx_data, tx_valid, WrEn, RdEn, Address, WrData, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, RdData,
        input  tx_data, tx_valid, WrEn, RdEn, Address, WrData, busy
    );
endinterface

// File: rtl/regfile_cmd_ctrl.sv
// Parses WR/RD command frames from the serial byte stream, drives RegFile
// and returns read words MSB-byte-first over a valid/ready byte channel.
module regfile_cmd_ctrl
    import regfile_cmd_ctrl_pkg::*;
#(
    parameter int         WIDTH  = 16,
    parameter int         ADDR   = 3,
    parameter logic [7:0] WR_CMD = WR_CMD_DEFAULT,
    parameter logic [7:0] RD_CMD = RD_CMD_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    regfile_cmd_ctrl_if.master bus
);

    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = $clog2(BYTES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] tx_shift;

    // The response byte is always the top byte of the shift register.
    assign bus.tx_data = tx_shift[WIDTH-1 -: 8];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tx_shift     <= '0;
            bus.tx_valid <= 1'b0;
            bus.WrEn     <= 1'b0;
            bus.RdEn     <= 1'b0;
            bus.Address  <= '0;
            bus.WrData   <= '0;
            bus.busy     <= 1'b0;
        end else begin
            bus.WrEn <= 1'b0;
            bus.RdEn <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == WR_CMD) begin
                            state <= WR_ADDR;
                        end else if (bus.rx_data == RD_CMD) begin
                            state <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (bus.rx_valid) begin
                        bus.Address <= bus.rx_data[ADDR-1:0];
                        cnt         <= '0;
                        state       <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (bus.rx_valid) begin
                        bus.WrData <= WIDTH'({bus.WrData, bus.rx_data});
                        cnt        <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            bus.WrEn <= 1'b1;
                            state    <= WR_EXEC;
                        end
                    end
                end
                WR_EXEC: begin
                    state <= IDLE;
                end
                RD_ADDR: begin
                    if (bus.rx_valid) begin
                        bus.Address <= bus.rx_data[ADDR-1:0];
                        bus.RdEn    <= 1'b1;
                        bus.busy    <= 1'b1;
                        state       <= RD_EXEC;
                    end
                end
                RD_EXEC: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    tx_shift     <= bus.RdData;
                    bus.tx_valid <= 1'b1;
                    cnt          <= '0;
                    state        <= TX_SEND;
                end
                TX_SEND: begin
                    // Shifting only on a handshake keeps tx_data frozen under back-pressure.
                    if (bus.tx_valid && bus.tx_ready) begin
                        if (cnt == LAST) begin
                            bus.tx_valid <= 1'b0;
                            bus.busy     <= 1'b0;
                            cnt          <= '0;
                            state        <= IDLE;
                        end else begin
                            tx_shift <= tx_shift << 8;
                            cnt      <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Randomized scoreboard bench for regfile_cmd_ctrl with a RegFile stub and
// a frame-level reference model of register contents.
module tb_regfile_cmd_ctrl;

    localparam int WIDTH = 16;
    localparam int ADDR  = 3;
    localparam int BYTES = WIDTH / 8;
    localparam int DEPTH = 1 << ADDR;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_cmd_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    regfile_cmd_ctrl #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR),
        .WR_CMD(8'hAA),
        .RD_CMD(8'hBB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // RegFile stub: write on WrEn, registered read data on RdEn
    logic [WIDTH-1:0] rf [DEPTH];
    always @(posedge clk) begin
        if (bus.WrEn) rf[bus.Address] <= bus.WrData;
        if (bus.RdEn) bus.RdData <= rf[bus.Address];
    end

    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [ADDR-1:0]  q_wr_addr [$];
    logic [WIDTH-1:0] q_wr_data [$];
    logic [ADDR-1:0]  q_rd_addr [$];
    logic [7:0]       q_tx      [$];

    int checks   = 0;
    int failures = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_WrEn"},     32'(bus.WrEn),     0);
        check({tag, "_RdEn"},     32'(bus.RdEn),     0);
        check({tag, "_Address"},  32'(bus.Address),  0);
        check({tag, "_WrData"},   32'(bus.WrData),   0);
        check({tag, "_tx_data"},  32'(bus.tx_data),  0);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 0);
        check({tag, "_busy"},     32'(bus.busy),     0);
    endtask

    // Transmit-ready driver
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = 1'($urandom_range(0, 1));
                default: bus.tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event
    initial begin
        logic       prev_v;
        logic       prev_r;
        logic [7:0] prev_d;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_d = '0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.WrEn && bus.RdEn) check("wr_rd_exclusive", 1, 0);
            if (bus.WrEn) begin
                if (q_wr_addr.size() == 0) begin
                    check("unexpected_WrEn", 32'(bus.Address), 32'hFFFF_FFFF);
                end else begin
                    check("wr_addr", 32'(bus.Address), 32'(q_wr_addr.pop_front()));
                    check("wr_data", 32'(bus.WrData),  32'(q_wr_data.pop_front()));
                end
            end
            if (bus.RdEn) begin
                if (q_rd_addr.size() == 0)
                    check("unexpected_RdEn", 32'(bus.Address), 32'hFFFF_FFFF);
                else
                    check("rd_addr", 32'(bus.Address), 32'(q_rd_addr.pop_front()));
            end
            if (rst && prev_v && !prev_r) begin
                check("tx_hold_valid", 32'(bus.tx_valid), 1);
                check("tx_hold_data",  32'(bus.tx_data),  32'(prev_d));
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (q_tx.size() == 0)
                    check("unexpected_tx", 32'(bus.tx_data), 32'hFFFF_FFFF);
                else
                    check("tx_byte", 32'(bus.tx_data), 32'(q_tx.pop_front()));
            end
            prev_v = bus.tx_valid;
            prev_r = bus.tx_ready;
            prev_d = bus.tx_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks are entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.busy && !bus.tx_valid) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("wait_idle_timeout", 32'(bus.busy), 0);
    endtask

    task automatic wait_tx_valid();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.tx_valid) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("wait_tx_valid_timeout", 32'(bus.tx_valid), 1);
    endtask

    task automatic expect_read(input logic [7:0] a8);
        logic [WIDTH-1:0] w;
        w = model_mem[a8 % DEPTH];
        q_rd_addr.push_back(ADDR'(a8 % DEPTH));
        for (int k = BYTES - 1; k >= 0; k--) q_tx.push_back(8'((w >> (8 * k)) & 'hFF));
    endtask

    task automatic do_write(input logic [7:0] a8, input logic [WIDTH-1:0] d);
        model_mem[a8 % DEPTH] = d;
        q_wr_addr.push_back(ADDR'(a8 % DEPTH));
        q_wr_data.push_back(d);
        send_byte(8'hAA);
        send_byte(a8);
        for (int k = BYTES - 1; k >= 0; k--) send_byte(8'((d >> (8 * k)) & 'hFF));
        idle(1);
    endtask

    task automatic do_read(input logic [7:0] a8);
        expect_read(a8);
        send_byte(8'hBB);
        send_byte(a8);
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            rf[i]        = '0;
            model_mem[i] = '0;
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        rst = 1'b0;
        @(negedge clk);

        // Frame offered while reset is held must never reach RegFile
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h0B);
        check_cleared("reset");
        rst = 1'b1;
        idle(2);

        do_write(8'h03, 16'h000B);
        do_write(8'h07, 16'h0001);
        do_write(8'h01, 16'h001C);
        do_read(8'h07);

        // Back-pressure on the first response byte
        ready_mode = 2;
        idle(1);
        expect_read(8'h01);
        send_byte(8'hBB);
        send_byte(8'h01);
        wait_tx_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_tx_valid", 32'(bus.tx_valid), 1);
            check("bp_tx_data",  32'(bus.tx_data),  32'h00);
            check("bp_busy",     32'(bus.busy),     1);
            @(negedge clk);
        end
        ready_mode = 0;
        wait_idle();
        check("after_bp_busy", 32'(bus.busy), 0);

        // Garbage byte, then address with upper bits set
        send_byte(8'h55);
        do_read(8'hFF);

        // Truncated write aborted by reset
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h12);
        rst = 1'b0;
        idle(2);
        check_cleared("abort");
        rst = 1'b1;
        idle(3);
        do_read(8'h02);

        // Command byte arriving during transmit is dropped
        ready_mode = 2;
        idle(1);
        expect_read(8'h03);
        send_byte(8'hBB);
        send_byte(8'h03);
        wait_tx_valid();
        send_byte(8'hAA);
        idle(2);
        ready_mode = 0;
        wait_idle();
        do_write(8'h05, 16'hBEEF);
        do_read(8'h05);

        // Randomized mix of writes, reads and stray bytes
        ready_mode = 1;
        for (int n = 0; n < 80; n++) begin
            int sel;
            logic [7:0] b;
            sel = int'($urandom_range(0, 9));
            b = 8'($urandom_range(0, 255));
            if (sel < 2) begin
                if (b == 8'hAA || b == 8'hBB) b = 8'h00;
                send_byte(b);
            end else if (sel < 6) begin
                do_write(b, WIDTH'($urandom));
            end else begin
                do_read(b);
            end
            idle(int'($urandom_range(0, 2)));
        end
        ready_mode = 0;
        idle(5);

        check("wr_queue_drained", 32'(q_wr_addr.size()), 0);
        check("rd_queue_drained", 32'(q_rd_addr.size()), 0);
        check("tx_queue_drained", 32'(q_tx.size()),      0);
        check("final_busy",       32'(bus.busy),         0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
